// File: rtl/latch_bank_arbiter.sv
// Round-robin write sequencer for a latch-built register file: setup / enable / hold / ack per write.
// Define LATCH_ARB_READBACK_EN to build the readback comparator that drives err.
module latch_bank_arbiter #(
  parameter int WIDTH  = 8,
  parameter int ADDR_W = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   req0,
  input  logic                   req1,
  input  logic [ADDR_W-1:0]      addr0,
  input  logic [ADDR_W-1:0]      addr1,
  input  logic [WIDTH-1:0]       data0,
  input  logic [WIDTH-1:0]       data1,
  output logic                   ack0,
  output logic                   ack1,
  output logic [WIDTH-1:0]       latch_d,
  output logic [(2**ADDR_W)-1:0] latch_en,
  output logic [ADDR_W-1:0]      rb_sel,
  input  logic [WIDTH-1:0]       rb_q,
  output logic                   busy,
  output logic                   err
);

  localparam int NWORDS = 2**ADDR_W;
  localparam logic [NWORDS-1:0] EN_ONE = NWORDS'(1);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] SETUP  = 3'd1;
  localparam logic [2:0] ENABLE = 3'd2;
  localparam logic [2:0] HOLD   = 3'd3;
  localparam logic [2:0] ACK    = 3'd4;

  logic [2:0] state;
  logic       gnt_id;
  logic       last_gnt;
  logic       pick;

  // On a tie the requester that was not granted last wins.
  always_comb begin
    pick = 1'b0;
    if (req0 && req1) pick = ~last_gnt;
    else              pick = req1;
  end

  // latch_d / rb_sel double as the captured data / address of the granted write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      gnt_id   <= 1'b0;
      last_gnt <= 1'b1;
      latch_d  <= '0;
      latch_en <= '0;
      rb_sel   <= '0;
      ack0     <= 1'b0;
      ack1     <= 1'b0;
      busy     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req0 || req1) begin
            gnt_id   <= pick;
            last_gnt <= pick;
            latch_d  <= pick ? data1 : data0;
            rb_sel   <= pick ? addr1 : addr0;
            busy     <= 1'b1;
            state    <= SETUP;
          end
        end
        SETUP: begin
          latch_en <= EN_ONE << rb_sel;
          state    <= ENABLE;
        end
        ENABLE: begin
          latch_en <= '0;
          state    <= HOLD;
        end
        HOLD: begin
          ack0  <= ~gnt_id;
          ack1  <= gnt_id;
          state <= ACK;
        end
        ACK: begin
          ack0  <= 1'b0;
          ack1  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          latch_en <= '0;
          ack0     <= 1'b0;
          ack1     <= 1'b0;
          busy     <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

`ifdef LATCH_ARB_READBACK_EN
  // Readback sampled at the HOLD->ACK edge so err lines up with the ack pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              err <= 1'b0;
    else if (state == HOLD)  err <= (rb_q != latch_d);
    else                     err <= 1'b0;
  end
`else
  logic rb_q_unused;
  assign rb_q_unused = ^rb_q;
  assign err         = 1'b0;
`endif

endmodule

// File: tb/tb_latch_bank_arbiter.sv
// Scoreboard bench for latch_bank_arbiter: directed writes, expected latch strobes and acks queued by the driver.
module tb_latch_bank_arbiter;

`ifdef LATCH_ARB_READBACK_EN
  localparam bit RB_EN = 1'b1;
`else
  localparam bit RB_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req0 = 1'b0, req1 = 1'b0;
  logic [1:0] addr0 = '0, addr1 = '0;
  logic [7:0] data0 = '0, data1 = '0;
  logic       ack0, ack1, busy, err;
  logic [7:0] latch_d, rb_q;
  logic [3:0] latch_en;
  logic [1:0] rb_sel;

  logic [7:0] mem [4] = '{default: 8'h00};
  logic [7:0] corrupt = 8'h00;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct { logic [3:0] en; logic [7:0] d; int cyc; } en_t;
  typedef struct { bit id; bit err; int cyc; } ack_t;
  en_t  en_q[$];
  ack_t ack_q[$];

  latch_bank_arbiter #(.WIDTH(8), .ADDR_W(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .req1(req1),
    .addr0(addr0), .addr1(addr1),
    .data0(data0), .data1(data1),
    .ack0(ack0), .ack1(ack1),
    .latch_d(latch_d), .latch_en(latch_en),
    .rb_sel(rb_sel), .rb_q(rb_q),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Latch bank model; corrupt flips bits on the way in to provoke readback errors.
  assign rb_q = mem[rb_sel];
  always @(negedge clk)
    for (int unsigned i = 0; i < 4; i++)
      if (rst_n && latch_en[i]) mem[i] <= latch_d ^ corrupt;

  logic [3:0] prev_en = '0;
  logic [7:0] prev_d  = '0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (latch_en != '0) begin
        checks++;
        if (en_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_latch_en got en=%b d=%h cyc=%0d", latch_en, latch_d, cyc);
        end else begin
          en_t e;
          e = en_q.pop_front();
          if (latch_en !== e.en || latch_d !== e.d || prev_d !== e.d || prev_en !== 4'b0000 || cyc != e.cyc) begin
            errors++;
            $display("FAIL latch_write got en=%b d=%h prev_d=%h prev_en=%b cyc=%0d want en=%b d=%h prev_en=0000 cyc=%0d",
                     latch_en, latch_d, prev_d, prev_en, cyc, e.en, e.d, e.cyc);
          end
        end
      end
      if (ack0 || ack1) begin
        checks++;
        if (ack_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_ack got ack0=%b ack1=%b cyc=%0d", ack0, ack1, cyc);
        end else begin
          ack_t a;
          logic [1:0] want;
          a = ack_q.pop_front();
          want = a.id ? 2'b10 : 2'b01;
          if ({ack1, ack0} !== want || err !== a.err || cyc != a.cyc || busy !== 1'b1) begin
            errors++;
            $display("FAIL ack got ack1ack0=%b err=%b busy=%b cyc=%0d want %b err=%b busy=1 cyc=%0d",
                     {ack1, ack0}, err, busy, cyc, want, a.err, a.cyc);
          end
        end
      end else begin
        checks++;
        if (err !== 1'b0) begin
          errors++;
          $display("FAIL err_without_ack got %b want 0 cyc=%0d", err, cyc);
        end
      end
    end
    prev_en = latch_en;
    prev_d  = latch_d;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  task automatic push_en(input logic [3:0] en, input logic [7:0] d, input int c);
    en_t e;
    e.en = en; e.d = d; e.cyc = c;
    en_q.push_back(e);
  endtask

  task automatic push_ack(input bit id, input bit e, input int c);
    ack_t a;
    a.id = id; a.err = e; a.cyc = c;
    ack_q.push_back(a);
  endtask

  task automatic wait_ack(input bit id);
    int n = 0;
    while (!(id ? ack1 : ack0) && n < 30) begin
      @(negedge clk);
      n++;
    end
    if (n >= 30) begin
      checks++;
      errors++;
      $display("FAIL ack_timeout id=%0d got no ack want ack within 30 cycles", id);
    end
  endtask

  task automatic drain_check(input string name);
    repeat (4) @(negedge clk);
    check({name, "_en_q_empty"}, en_q.size(), 0);
    check({name, "_ack_q_empty"}, ack_q.size(), 0);
    en_q.delete();
    ack_q.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req0 = 1'b0;
    req1 = 1'b0;
    corrupt = 8'h00;
    repeat (2) @(negedge clk);
    check("rst_latch_en", latch_en, 0);
    check("rst_latch_d", latch_d, 0);
    check("rst_rb_sel", rb_sel, 0);
    check("rst_acks", {ack1, ack0}, 0);
    check("rst_busy", busy, 0);
    check("rst_err", err, 0);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  int k;

  initial begin
    #200000;
    $display("FAIL global_timeout got no finish want finish");
    $fatal(1);
  end

  initial begin
    do_reset();

    // Single write, data changed after grant must not reach the latch.
    k = cyc + 1;
    req0 = 1'b1; addr0 = 2'd2; data0 = 8'hA5;
    push_en(4'b0100, 8'hA5, k + 1);
    push_ack(1'b0, 1'b0, k + 3);
    @(negedge clk);
    data0 = 8'hFF;
    wait_ack(1'b0);
    req0 = 1'b0;
    drain_check("single");
    check("mem2_value", mem[2], 8'hA5);
    check("idle_hold_latch_d", latch_d, 8'hA5);
    check("idle_hold_rb_sel", rb_sel, 2'd2);
    check("idle_busy", busy, 0);

    // Simultaneous requests from reset: 0 first, 1 five cycles later.
    do_reset();
    k = cyc + 1;
    req0 = 1'b1; addr0 = 2'd1; data0 = 8'h11;
    req1 = 1'b1; addr1 = 2'd3; data1 = 8'h33;
    push_en(4'b0010, 8'h11, k + 1);
    push_ack(1'b0, 1'b0, k + 3);
    push_en(4'b1000, 8'h33, k + 6);
    push_ack(1'b1, 1'b0, k + 8);
    wait_ack(1'b0);
    req0 = 1'b0;
    wait_ack(1'b1);
    req1 = 1'b1;
    req1 = 1'b0;
    drain_check("tie");

    // Both requests held for four transactions: grants alternate 0,1,0,1.
    do_reset();
    k = cyc + 1;
    req0 = 1'b1; addr0 = 2'd0; data0 = 8'h5A;
    req1 = 1'b1; addr1 = 2'd3; data1 = 8'hC3;
    for (int i = 0; i < 4; i++) begin
      push_en((i % 2) ? 4'b1000 : 4'b0001, (i % 2) ? 8'hC3 : 8'h5A, k + 5 * i + 1);
      push_ack(bit'(i % 2), 1'b0, k + 5 * i + 3);
    end
    for (int i = 0; i < 4; i++) wait_ack(bit'(i % 2));
    req0 = 1'b0;
    req1 = 1'b0;
    drain_check("stream");

    // Readback: clean write, then a write corrupted on the way into the latch.
    k = cyc + 1;
    req1 = 1'b1; addr1 = 2'd2; data1 = 8'h96;
    push_en(4'b0100, 8'h96, k + 1);
    push_ack(1'b1, 1'b0, k + 3);
    wait_ack(1'b1);
    req1 = 1'b0;
    drain_check("rb_clean");
    corrupt = 8'h01;
    k = cyc + 1;
    req1 = 1'b1; addr1 = 2'd1; data1 = 8'h69;
    push_en(4'b0010, 8'h69, k + 1);
    push_ack(1'b1, RB_EN, k + 3);
    wait_ack(1'b1);
    req1 = 1'b0;
    drain_check("rb_corrupt");
    corrupt = 8'h00;

    // Reset during ENABLE: strobe drops asynchronously, no ack follows.
    do_reset();
    k = cyc + 1;
    req0 = 1'b1; addr0 = 2'd1; data0 = 8'h3C;
    push_en(4'b0010, 8'h3C, k + 1);
    repeat (2) @(negedge clk);
    check("pre_abort_en", latch_en, 4'b0010);
    #2;
    rst_n = 1'b0;
    req0 = 1'b0;
    #1;
    check("abort_en_async", latch_en, 0);
    check("abort_busy", busy, 0);
    check("abort_acks", {ack1, ack0}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    check("after_abort_busy", busy, 0);
    check("after_abort_en", latch_en, 0);
    drain_check("abort");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
